// File: rtl/mpu6050_pkg.sv
// Shared MPU6050 definitions: selector codes, device address and sequencer state encoding.
// Used by the selector sequencer and by the I2C transaction state machine.
package mpu6050_pkg;

  localparam logic [2:0] SEL_IDLE    = 3'b000;
  localparam logic [2:0] SEL_WR_PWR  = 3'b001;
  localparam logic [2:0] SEL_WR_GYRO = 3'b011;
  localparam logic [2:0] SEL_RD_44   = 3'b100;
  localparam logic [2:0] SEL_RD_43   = 3'b110;

  localparam logic [6:0] MPU_ADDR = 7'h68;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_PWRUP = 4'd0;
  localparam seq_state_t ST_WR1   = 4'd1;
  localparam seq_state_t ST_G1    = 4'd2;
  localparam seq_state_t ST_WR2   = 4'd3;
  localparam seq_state_t ST_G2    = 4'd4;
  localparam seq_state_t ST_RD1   = 4'd5;
  localparam seq_state_t ST_G3    = 4'd6;
  localparam seq_state_t ST_RD2   = 4'd7;
  localparam seq_state_t ST_G4    = 4'd8;
  localparam seq_state_t ST_WAIT  = 4'd9;
  localparam seq_state_t ST_PARK  = 4'd10;

  function automatic logic [2:0] sel_code(input seq_state_t st);
    case (st)
      ST_WR1:  sel_code = SEL_WR_PWR;
      ST_WR2:  sel_code = SEL_WR_GYRO;
      ST_RD1:  sel_code = SEL_RD_44;
      ST_RD2:  sel_code = SEL_RD_43;
      default: sel_code = SEL_IDLE;
    endcase
  endfunction

  function automatic logic is_txn(input seq_state_t st);
    case (st)
      ST_WR1, ST_WR2, ST_RD1, ST_RD2: is_txn = 1'b1;
      default:                        is_txn = 1'b0;
    endcase
  endfunction

  function automatic logic is_gap(input seq_state_t st);
    case (st)
      ST_G1, ST_G2, ST_G3, ST_G4: is_gap = 1'b1;
      default:                    is_gap = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mpu6050_selector_sequencer_seq_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags an expired count.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mpu6050_selector_sequencer.sv
// Drives the I2C transaction selector through MPU6050 power-up, configuration and periodic gyro reads.
// Optional MPU_SEQ_BUSY_HANDSHAKE_EN: slots end on txn_busy falling edge, TXN_CYCLES acts as timeout.
module mpu6050_selector_sequencer
  import mpu6050_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 5_000_000,
  parameter int unsigned TXN_CYCLES     = 50_000,
  parameter int unsigned GAP_CYCLES     = 1_000,
  parameter int unsigned SAMPLE_PERIOD  = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef MPU_SEQ_BUSY_HANDSHAKE_EN
  input  logic       txn_busy,
  output logic       timeout_err,
`endif
  output logic [2:0] selector,
  output logic       init_done,
  output logic       sample_tick,
  output logic       busy
);

  localparam int unsigned SLOT_MAX_A = (POWERUP_CYCLES > TXN_CYCLES) ? POWERUP_CYCLES : TXN_CYCLES;
  localparam int unsigned SLOT_MAX   = (SLOT_MAX_A > GAP_CYCLES) ? SLOT_MAX_A : GAP_CYCLES;
  localparam int unsigned SW         = $clog2(SLOT_MAX + 1);
  localparam int unsigned PW         = $clog2(SAMPLE_PERIOD + 1);

  // The first counted power-up cycle is the load cycle, hence the extra decrement.
  localparam logic [SW-1:0] PWR_LD  = SW'((POWERUP_CYCLES >= 2) ? (POWERUP_CYCLES - 2) : 0);
  localparam logic          PWR_ONE = (POWERUP_CYCLES <= 1) ? 1'b1 : 1'b0;
  localparam logic [SW-1:0] TXN_LD  = SW'(TXN_CYCLES - 1);
  localparam logic [SW-1:0] GAP_LD  = SW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PER_LD  = PW'(SAMPLE_PERIOD - 1);

  seq_state_t    state_q, state_d;
  logic          pwr_started_q, pwr_started_d;
  logic          init_done_q, init_done_d;
  logic          tick_q, tick_d;
  logic [2:0]    selector_q;
  logic          busy_q;

  logic          slot_load_s;
  logic [SW-1:0] slot_val_s;
  logic          slot_en_s;
  logic          slot_zero_s;
  logic          per_load_s;
  logic          per_zero_s;
  logic          pwr_last_s;
  logic          txn_end_s;

  assign pwr_last_s = pwr_started_q ? slot_zero_s : PWR_ONE;

`ifdef MPU_SEQ_BUSY_HANDSHAKE_EN
  logic seen_q, seen_d;
  logic timeout_q, timeout_d;
  logic fall_s;

  assign fall_s    = seen_q & ~txn_busy;
  assign txn_end_s = fall_s | slot_zero_s;

  // Busy-seen tracking restarts with every transaction slot; timeout is sticky.
  always_comb begin
    seen_d    = 1'b0;
    timeout_d = timeout_q;
    if (is_txn(state_q) && (state_d == state_q)) begin
      seen_d = seen_q | txn_busy;
    end else begin
      seen_d = 1'b0;
    end
    if (is_txn(state_q) && slot_zero_s && !fall_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      seen_q    <= seen_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign txn_end_s = slot_zero_s;
`endif

  // Next-state logic; gap exits decide between continuing and parking.
  always_comb begin
    state_d       = state_q;
    pwr_started_d = pwr_started_q;
    init_done_d   = init_done_q;
    tick_d        = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (run && pwr_last_s) begin
          state_d = ST_WR1;
        end else if (run) begin
          pwr_started_d = 1'b1;
        end else begin
          state_d = ST_PWRUP;
        end
      end
      ST_WR1: begin
        if (txn_end_s) state_d = ST_G1; else state_d = ST_WR1;
      end
      ST_G1: begin
        if (slot_zero_s) state_d = run ? ST_WR2 : ST_PARK; else state_d = ST_G1;
      end
      ST_WR2: begin
        if (txn_end_s) state_d = ST_G2; else state_d = ST_WR2;
      end
      ST_G2: begin
        if (slot_zero_s) begin
          init_done_d = 1'b1;
          state_d     = run ? ST_RD1 : ST_PARK;
        end else begin
          state_d = ST_G2;
        end
      end
      ST_RD1: begin
        if (txn_end_s) state_d = ST_G3; else state_d = ST_RD1;
      end
      ST_G3: begin
        if (slot_zero_s) state_d = run ? ST_RD2 : ST_PARK; else state_d = ST_G3;
      end
      ST_RD2: begin
        if (txn_end_s) begin
          state_d = ST_G4;
          tick_d  = 1'b1;
        end else begin
          state_d = ST_RD2;
        end
      end
      ST_G4: begin
        if (!slot_zero_s)    state_d = ST_G4;
        else if (!run)       state_d = ST_PARK;
        else if (per_zero_s) state_d = ST_RD1;
        else                 state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!run)            state_d = ST_PARK;
        else if (per_zero_s) state_d = ST_RD1;
        else                 state_d = ST_WAIT;
      end
      ST_PARK: begin
        if (run) state_d = init_done_q ? ST_RD1 : ST_WR1; else state_d = ST_PARK;
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Slot timer reloads on every state change and on the first counted power-up cycle.
  always_comb begin
    slot_load_s = (state_d != state_q) ||
                  ((state_q == ST_PWRUP) && run && !pwr_started_q);
    slot_en_s   = (state_q == ST_PWRUP) ? (run & pwr_started_q) : 1'b1;
    if (is_txn(state_d)) begin
      slot_val_s = TXN_LD;
    end else if (is_gap(state_d)) begin
      slot_val_s = GAP_LD;
    end else if (state_d == ST_PWRUP) begin
      slot_val_s = PWR_LD;
    end else begin
      slot_val_s = '0;
    end
  end

  assign per_load_s = (state_d == ST_RD1) && (state_q != ST_RD1);

  seq_timer #(.W(SW)) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (slot_load_s),
    .load_val_i (slot_val_s),
    .en_i       (slot_en_s),
    .zero_o     (slot_zero_s)
  );

  seq_timer #(.W(PW)) u_period_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (per_load_s),
    .load_val_i (PER_LD),
    .en_i       (1'b1),
    .zero_o     (per_zero_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_PWRUP;
      pwr_started_q <= 1'b0;
      init_done_q   <= 1'b0;
      tick_q        <= 1'b0;
      selector_q    <= SEL_IDLE;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwr_started_q <= pwr_started_d;
      init_done_q   <= init_done_d;
      tick_q        <= tick_d;
      selector_q    <= sel_code(state_d);
      busy_q        <= (sel_code(state_d) != SEL_IDLE);
    end
  end

  assign selector    = selector_q;
  assign init_done   = init_done_q;
  assign sample_tick = tick_q;
  assign busy        = busy_q;

endmodule
